// File: rtl/handshake_arbiter.sv
// Purpose : round-robin arbiter sharing one 4-phase sync/ack slave among N_REQ
//           4-phase sync/ack requesters; each grant is fully sequenced on the
//           slave side (sync up, ack up, sync down, ack down) before the
//           requester is acknowledged.
// Latency : with a slave answering on the next edge, slv_sync rises after the
//           granting edge (edge 1) and req_ack rises after edge 5; one idle
//           cycle separates back-to-back grants.
// Backpressure: requests arriving while busy stay pending (requesters hold
//           sync high); no grant is issued while the slave still shows ack.
// Ports   : clock/reset (async, active-high); req_sync/req_ack/req_data_in
//           requester side; req_data_out shared result (valid while
//           req_ack[grant_id]); grant_id/busy status; slv_sync/slv_ack/
//           slv_data_in/slv_data_out slave side; timeout sticky watchdog flag.
// Option  : define HANDSHAKE_ARBITER_TIMEOUT_EN to enable the ISSUE/RELEASE
//           watchdog; otherwise timeout is tied 0 and the FSM waits forever.
module handshake_arbiter #(
  parameter int N_REQ          = 4,
  parameter int IN_WIDTH       = 32,
  parameter int OUT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_sync,
  output logic [N_REQ-1:0]            req_ack,
  input  logic [N_REQ*IN_WIDTH-1:0]   req_data_in,
  output logic [OUT_WIDTH-1:0]        req_data_out,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy,
  output logic                        slv_sync,
  input  logic                        slv_ack,
  output logic [IN_WIDTH-1:0]         slv_data_in,
  input  logic [OUT_WIDTH-1:0]        slv_data_out,
  output logic                        timeout
);

  localparam int GW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("handshake_arbiter: N_REQ must be 2..16 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [GW-1:0]          rr_ptr, rr_ptr_nxt;
  logic [GW-1:0]          grant_id_nxt;
  logic [N_REQ-1:0]       req_ack_nxt;
  logic [OUT_WIDTH-1:0]   req_data_out_nxt;
  logic                   busy_nxt;
  logic                   slv_sync_nxt;
  logic [IN_WIDTH-1:0]    slv_data_in_nxt;
  logic                   timeout_nxt;
  logic                   abort;

  // Per-requester operand view of the flattened input bus.
  logic [IN_WIDTH-1:0] operand [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_operand
    assign operand[g] = req_data_in[g*IN_WIDTH +: IN_WIDTH];
  end

  // Round-robin pick: scan from rr_ptr upward modulo N_REQ. The loop runs
  // downward so the last hit written is the nearest index at/after rr_ptr.
  // A requester still holding ack (finishing its handshake) is not eligible.
  logic [GW:0]   scan_sum;
  logic [GW-1:0] cand;
  logic [GW-1:0] win_idx;
  logic          win_vld;

  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    scan_sum = '0;
    cand     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      scan_sum = {1'b0, rr_ptr} + (GW+1)'(k);
      if (scan_sum >= (GW+1)'(N_REQ)) begin
        scan_sum = scan_sum - (GW+1)'(N_REQ);
      end
      cand = scan_sum[GW-1:0];
      if (req_sync[cand] && !req_ack[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef HANDSHAKE_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;

  // The counter holds the number of edges already spent in ISSUE/RELEASE;
  // the edge that would make it TIMEOUT_CYCLES aborts instead.
  assign abort = (state == ISSUE || state == RELEASE) &&
                 (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == IDLE) begin
      wd_cnt <= '0;
    end else if (state == ISSUE || state == RELEASE) begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt        = state;
    rr_ptr_nxt       = rr_ptr;
    grant_id_nxt     = grant_id;
    req_ack_nxt      = req_ack;
    req_data_out_nxt = req_data_out;
    busy_nxt         = busy;
    slv_sync_nxt     = slv_sync;
    slv_data_in_nxt  = slv_data_in;
    timeout_nxt      = timeout;
    case (state)
      IDLE: begin
        // slv_ack guard: after a reset or an aborted transfer the slave may
        // still be acked; wait for it to settle before issuing anew.
        if (win_vld && !slv_ack) begin
          grant_id_nxt    = win_idx;
          slv_data_in_nxt = operand[win_idx];
          slv_sync_nxt    = 1'b1;
          busy_nxt        = 1'b1;
          state_nxt       = ISSUE;
        end
      end
      ISSUE: begin
        if (slv_ack) begin
          req_data_out_nxt = slv_data_out;
          slv_sync_nxt     = 1'b0;
          state_nxt        = RELEASE;
        end
      end
      RELEASE: begin
        if (!slv_ack) begin
          req_ack_nxt[grant_id] = 1'b1;
          state_nxt             = RESPOND;
        end
      end
      RESPOND: begin
        // A requester that dropped sync early falls straight through here.
        if (!req_sync[grant_id]) begin
          req_ack_nxt = '0;
          rr_ptr_nxt  = (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + GW'(1);
          busy_nxt    = 1'b0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Watchdog abort still acknowledges the requester, with an all-ones result.
    if (abort && !(state == ISSUE && slv_ack) && !(state == RELEASE && !slv_ack)) begin
      slv_sync_nxt          = 1'b0;
      req_data_out_nxt      = '1;
      timeout_nxt           = 1'b1;
      req_ack_nxt           = '0;
      req_ack_nxt[grant_id] = 1'b1;
      state_nxt             = RESPOND;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      req_ack      <= '0;
      req_data_out <= '0;
      busy         <= 1'b0;
      slv_sync     <= 1'b0;
      slv_data_in  <= '0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_ptr_nxt;
      grant_id     <= grant_id_nxt;
      req_ack      <= req_ack_nxt;
      req_data_out <= req_data_out_nxt;
      busy         <= busy_nxt;
      slv_sync     <= slv_sync_nxt;
      slv_data_in  <= slv_data_in_nxt;
    end
  end

`ifdef HANDSHAKE_ARBITER_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout <= 1'b0;
    end else begin
      timeout <= timeout_nxt;
    end
  end
`else
  assign timeout = 1'b0;
  logic unused_timeout_nxt;
  assign unused_timeout_nxt = timeout_nxt;
`endif

endmodule

// File: doc/handshake_arbiter.md
Name: handshake_arbiter

Overview:
- Shares one 4-phase sync/ack slave (e.g. the +1 counter datapath) among N_REQ requesters, each speaking the same 4-phase sync/ack protocol.
- Round-robin grant. Each granted transaction is sequenced fully on the slave side before the requester is acknowledged.
- Sits between the host-side masters and a single shared compute slave.

Parameters:
- N_REQ, 4: number of requesters, 2..16.
- IN_WIDTH, 32: width of each requester's operand and of the slave's data_in.
- OUT_WIDTH, 32: width of the slave result and of the shared result bus.
- TIMEOUT_CYCLES, 1024: watchdog limit, used only with the optional feature.

Ports:
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_sync  in  N_REQ  per-requester sync; bit i belongs to requester i.
- req_ack  out  N_REQ  per-requester ack, registered.
- req_data_in  in  N_REQ*IN_WIDTH  flattened operands; requester i occupies bits [i*IN_WIDTH +: IN_WIDTH].
- req_data_out  out  OUT_WIDTH  shared result; valid while req_ack[grant] is 1.
- grant_id  out  clog2(N_REQ)  index of the requester currently granted.
- busy  out  1  high in every state except IDLE.
- slv_sync  out  1  sync to the shared slave, registered.
- slv_ack  in  1  ack from the shared slave.
- slv_data_in  out  IN_WIDTH  operand to the slave, registered.
- slv_data_out  in  OUT_WIDTH  result from the slave.
- timeout  out  1  sticky watchdog flag; tied 0 when the feature is off.

Behaviour:
- Reset values (asynchronous): req_ack=0, req_data_out=0, grant_id=0, busy=0, slv_sync=0, slv_data_in=0, timeout=0, state=IDLE, rr_ptr=0.
- Reset mid-operation: all outputs drop immediately. No transaction is resumed.
- FSM, one state register, all outputs registered:
  - IDLE:
    - Eligible requester i: req_sync[i]=1 and req_ack[i]=0.
    - A grant is issued only if slv_ack=0. This guard prevents re-issue after reset while the slave is still acked.
    - Winner: first eligible index scanning rr_ptr, rr_ptr+1, … mod N_REQ.
    - On a win: grant_id<=winner; slv_data_in<=operand of the winner; slv_sync<=1; busy<=1; go to ISSUE.
  - ISSUE:
    - Hold slv_sync=1 until slv_ack=1.
    - Then: req_data_out<=slv_data_out; slv_sync<=0; go to RELEASE.
  - RELEASE:
    - Wait for slv_ack=0.
    - Then: req_ack[grant_id]<=1; go to RESPOND.
  - RESPOND:
    - Wait for req_sync[grant_id]=0.
    - Then: req_ack[grant_id]<=0; rr_ptr<=(grant_id+1) mod N_REQ; busy<=0; go to IDLE.
- Grant and ordering rules:
  - At most one req_ack bit is high at any time.
  - req_data_out holds its value until the next capture.
  - Requests arriving while busy are held pending. Requesters keep sync high and are not dropped.
  - If several requests are simultaneous, the lowest index at or after rr_ptr wins.
  - A requester that just completed has lowest priority on the next grant.
- A requester that drops req_sync before ack is a protocol violation. The transaction still completes, and RESPOND exits on the first cycle.
- Latency, with a slave answering on the next edge:
  - Count the IDLE edge that samples req_sync as edge 1.
  - slv_sync rises after edge 1.
  - req_ack rises after edge 5.
  - Back-to-back grants have 1 idle cycle in IDLE.
- Width rules:
  - No arithmetic on data; slices pass through.
  - rr_ptr wrap uses an explicit compare with N_REQ-1, so non-power-of-2 N_REQ is legal.

Optional Feature:
- Macro: HANDSHAKE_ARBITER_TIMEOUT_EN.
- When defined:
  - A watchdog counter clears on entry to ISSUE and counts in ISSUE and RELEASE.
  - On reaching TIMEOUT_CYCLES: slv_sync<=0; req_data_out<=all ones; timeout<=1 (sticky until reset); go to RESPOND, so the requester is still acknowledged.
  - An aborted transaction leaves IDLE blocked until slv_ack=0, per the existing guard.
- When undefined:
  - No counter logic.
  - timeout is constant 0.
  - ISSUE and RELEASE wait indefinitely.

Test Plan:
- Single request: N_REQ=4, requester 2 with operand 0x00000010 and a +1 slave → req_data_out=0x00000011, req_ack[2] rises after edge 5, grant_id=2, drops one cycle after req_sync[2] falls.
- Simultaneous requests from 0, 1 and 3 with operands 5, 7, 9 → service order 0, 1, 3; results 6, 8, 10; never two req_ack bits high at once.
- Fairness: requesters 0 and 1 continuously re-request → grants alternate 0, 1, 0, 1 over 8 transactions.
- Reset asserted while in ISSUE with slv_ack stuck at 1 → all outputs 0 at once; after release no slv_sync until slv_ack=0, then pending request served normally.
- Wrap: operand 0xFFFFFFFF → req_data_out=0x00000000; rr_ptr wraps 3→0 after requester 3 is served.
- With HANDSHAKE_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never acks → at cycle 16 slv_sync drops, req_data_out=0xFFFFFFFF, timeout=1, req_ack[grant] rises.
